// File: rtl/axi_lite_led_responder.sv
// AXI4-Lite responder for the LED register window: LED, write counter, scratch, status.
// Includes an LED-write watchdog that raises stale after TIMEOUT_CYCLES idle cycles.
module axi_lite_led_responder #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                  S_AXI_AWPROT,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                  S_AXI_ARPROT,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    output logic [3:0]                  leds,
    output logic                        stale
);
    localparam int              CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   TMO = CW'(TIMEOUT_CYCLES);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam int              NB = AXI_DATA_WIDTH / 8;

    logic                      run_q, run_d;
    logic                      aw_cap_q, aw_cap_d;
    logic [1:0]                aw_idx_q, aw_idx_d;
    logic                      w_cap_q, w_cap_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NB-1:0]             w_strb_q, w_strb_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]                led_q, led_d;
    logic [AXI_DATA_WIDTH-1:0] wcount_q, wcount_d;
    logic [AXI_DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [CW-1:0]             wdog_q, wdog_d;
    logic                      stale_q, stale_d;

    logic aw_hs, w_hs, ar_hs, commit, led_commit;

    // Readies stay low until the first edge after reset so every output is 0 while in reset.
    assign S_AXI_AWREADY = run_q && !aw_cap_q && !bvalid_q;
    assign S_AXI_WREADY  = run_q && !w_cap_q && !bvalid_q;
    assign S_AXI_ARREADY = run_q && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign leds          = led_q;
    assign stale         = stale_q;

    assign aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs       = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit     = aw_cap_q && w_cap_q;
    assign led_commit = commit && (aw_idx_q == 2'd0);

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR[AXI_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0],
                           S_AXI_AWPROT, S_AXI_ARPROT};

    always_comb begin
        run_d     = 1'b1;
        aw_cap_d  = aw_cap_q;
        aw_idx_d  = aw_idx_q;
        w_cap_d   = w_cap_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        led_d     = led_q;
        wcount_d  = wcount_q;
        scratch_d = scratch_q;

        if (aw_hs) begin
            aw_cap_d = 1'b1;
            aw_idx_d = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_cap_d  = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

        if (commit) begin
            aw_cap_d = 1'b0;
            w_cap_d  = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (aw_idx_q)
                2'd0: begin
                    if (w_strb_q[0]) led_d = w_data_q[3:0];
                    wcount_d = wcount_q + 1'b1;
                end
                2'd2: begin
                    for (int b = 0; b < NB; b++)
                        if (w_strb_q[b]) scratch_d[8*b +: 8] = w_data_q[8*b +: 8];
                end
                default: bresp_d = RESP_SLVERR;
            endcase
        end
    end

    // Read data comes from the _q registers, so a same-edge commit is not visible yet.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            case (S_AXI_ARADDR[3:2])
                2'd0:    rdata_d = {{(AXI_DATA_WIDTH-4){1'b0}}, led_q};
                2'd1:    rdata_d = wcount_q;
                2'd2:    rdata_d = scratch_q;
                default: rdata_d = {{(AXI_DATA_WIDTH-1){1'b0}}, stale_q};
            endcase
        end
    end

    always_comb begin
        wdog_d = (wdog_q == TMO) ? wdog_q : wdog_q + 1'b1;
        if (led_commit) wdog_d = '0;
        stale_d = (wdog_d == TMO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q     <= 1'b0;
            aw_cap_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_cap_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            led_q     <= '0;
            wcount_q  <= '0;
            scratch_q <= '0;
            wdog_q    <= '0;
            stale_q   <= 1'b0;
        end else begin
            run_q     <= run_d;
            aw_cap_q  <= aw_cap_d;
            aw_idx_q  <= aw_idx_d;
            w_cap_q   <= w_cap_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            wcount_q  <= wcount_d;
            scratch_q <= scratch_d;
            wdog_q    <= wdog_d;
            stale_q   <= stale_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_led_responder.sv
// Directed bench for axi_lite_led_responder: vector table plus hand-written handshake sequences.
module tb_axi_lite_led_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid, stale;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  leds;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_led_responder #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .leds(leds), .stale(stale)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write with AW and W presented together; returns BRESP and stale as seen with BVALID.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp, output logic st);
        logic aw_done, w_done, ar, wr_, got;
        aw_done = 0; w_done = 0; got = 0; resp = 2'bxx; st = 1'bx;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 30 && !(aw_done && w_done); i++) begin
            @(negedge clk); ar = awready; wr_ = wready;
            @(posedge clk); #1;
            if (ar && awvalid) begin aw_done = 1; awvalid = 0; end
            if (wr_ && wvalid) begin w_done = 1; wvalid = 0; end
        end
        awvalid = 0; wvalid = 0;
        chk("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
        bready = 1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bvalid) begin got = 1; resp = bresp; st = stale; end
        end
        chk("wr_bvalid_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1; bready = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic done, ok, got;
        done = 0; got = 0; d = 'x; resp = 2'bxx;
        @(posedge clk); #1;
        araddr = a; arvalid = 1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk); ok = arready;
            @(posedge clk); #1;
            if (ok) begin done = 1; arvalid = 0; end
        end
        arvalid = 0;
        chk("rd_handshake", {31'd0, done}, 32'd1);
        rready = 1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (rvalid) begin got = 1; d = rdata; resp = rresp; end
        end
        chk("rd_rvalid_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1; rready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 reset = 1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        @(negedge clk); reset = 0;
    endtask

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [3:0]  exp_leds;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic        st, held;

        // exp = BRESP for writes, RDATA for reads. State entering table: leds=8, WCOUNT=2, SCRATCH=0.
        tbl[0]  = '{1'b0, 32'h4000_0004, 32'h0000_FFFF, 4'hF, 32'h2,         4'h8};
        tbl[1]  = '{1'b1, 32'h4000_0004, 32'h0,         4'h0, 32'h2,         4'h8};
        tbl[2]  = '{1'b0, 32'h4000_000C, 32'h1,         4'hF, 32'h2,         4'h8};
        tbl[3]  = '{1'b1, 32'h4000_0004, 32'h0,         4'h0, 32'h2,         4'h8};
        tbl[4]  = '{1'b0, 32'h4000_0008, 32'h0,         4'hF, 32'h0,         4'h8};
        tbl[5]  = '{1'b0, 32'h4000_0008, 32'hAABB_CCDD, 4'h5, 32'h0,         4'h8};
        tbl[6]  = '{1'b1, 32'h4000_0008, 32'h0,         4'h0, 32'h00BB_00DD, 4'h8};
        tbl[7]  = '{1'b0, 32'h4000_0000, 32'h3,         4'hE, 32'h0,         4'h8};
        tbl[8]  = '{1'b1, 32'h4000_0004, 32'h0,         4'h0, 32'h3,         4'h8};
        tbl[9]  = '{1'b1, 32'h4000_0000, 32'h0,         4'h0, 32'h8,         4'h8};
        tbl[10] = '{1'b0, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0,         4'hF};
        tbl[11] = '{1'b1, 32'h4000_0000, 32'h0,         4'h0, 32'hF,         4'hF};
        tbl[12] = '{1'b1, 32'h4000_0004, 32'h0,         4'h0, 32'h4,         4'hF};
        tbl[13] = '{1'b1, 32'h4000_000C, 32'h0,         4'h0, 32'h0,         4'hF};
        tbl[14] = '{1'b0, 32'h4000_0008, 32'h1122_3344, 4'hA, 32'h0,         4'hF};
        tbl[15] = '{1'b1, 32'h4000_0008, 32'h0,         4'h0, 32'h11BB_33DD, 4'hF};
        tbl[16] = '{1'b1, 32'h1234_0010, 32'h0,         4'h0, 32'hF,         4'hF};

        // Reset state
        #3;
        chk("reset_outputs", {21'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, stale},
            32'd0);
        chk("reset_leds", {28'd0, leds}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk); reset = 0;
        repeat (2) @(posedge clk);

        // 1: AW first, W three cycles later
        #1 awaddr = 32'h4000_0000; awvalid = 1;
        @(negedge clk); chk("t1_awready", {31'd0, awready}, 32'd1);
        @(posedge clk); #1 awvalid = 0;
        repeat (2) @(posedge clk);
        #1 wdata = 32'h5; wstrb = 4'hF; wvalid = 1;
        @(negedge clk); chk("t1_wready", {31'd0, wready}, 32'd1);
        @(posedge clk); #1 wvalid = 0;
        @(negedge clk); chk("t1_b_not_early", {31'd0, bvalid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_bvalid", {31'd0, bvalid}, 32'd1);
        chk("t1_bresp", {30'd0, bresp}, 32'd0);
        chk("t1_leds", {28'd0, leds}, 32'h5);
        bready = 1;
        @(posedge clk); #1 bready = 0;
        @(negedge clk); chk("t1_b_cleared", {31'd0, bvalid}, 32'd0);
        rd(32'h4000_0004, d, resp);
        chk("t1_wcount", d, 32'd1);

        // 2: W first, AW four cycles later, BREADY held low for 10 cycles
        @(posedge clk); #1 wdata = 32'h8; wstrb = 4'hF; wvalid = 1;
        @(negedge clk); chk("t2_wready", {31'd0, wready}, 32'd1);
        @(posedge clk); #1 wvalid = 0;
        @(negedge clk);
        chk("t2_w_blocked", {30'd0, awready, wready}, 32'b10);
        repeat (3) @(posedge clk);
        #1 awaddr = 32'h4000_0000; awvalid = 1;
        @(negedge clk); chk("t2_awready", {31'd0, awready}, 32'd1);
        @(posedge clk); #1 awvalid = 0;
        @(posedge clk);
        held = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            held = held && bvalid && !awready && !wready;
        end
        chk("t2_b_held", {31'd0, held}, 32'd1);
        chk("t2_leds", {28'd0, leds}, 32'h8);
        bready = 1;
        @(posedge clk); #1 bready = 0;
        @(negedge clk); chk("t2_ready_again", {30'd0, bvalid, awready}, 32'b01);

        // 3/4: table of single transactions
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rd) begin
                rd(tbl[i].addr, d, resp);
                chk($sformatf("vec%0d_rdata", i), d, tbl[i].exp);
                chk($sformatf("vec%0d_rresp", i), {30'd0, resp}, 32'd0);
            end else begin
                wr(tbl[i].addr, tbl[i].data, tbl[i].strb, resp, st);
                chk($sformatf("vec%0d_bresp", i), {30'd0, resp}, tbl[i].exp);
            end
            chk($sformatf("vec%0d_leds", i), {28'd0, leds}, {28'd0, tbl[i].exp_leds});
        end

        // 5: watchdog with TIMEOUT_CYCLES=100
        do_reset();
        repeat (99) @(posedge clk);
        @(negedge clk); chk("t5_stale_99", {31'd0, stale}, 32'd0);
        @(posedge clk);
        @(negedge clk); chk("t5_stale_100", {31'd0, stale}, 32'd1);
        rd(32'h4000_000C, d, resp);
        chk("t5_status", d, 32'd1);
        chk("t5_stale_before_write", {31'd0, stale}, 32'd1);
        wr(32'h4000_0000, 32'h2, 4'hF, resp, st);
        chk("t5_stale_at_commit", {31'd0, st}, 32'd0);

        // 6: reset while BVALID and RVALID are both high
        @(posedge clk); #1;
        awaddr = 32'h4000_0000; wdata = 32'h9; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'h4000_0004; arvalid = 1;
        @(posedge clk); #1 awvalid = 0; wvalid = 0; arvalid = 0;
        @(posedge clk);
        @(negedge clk); chk("t6_pending", {30'd0, bvalid, rvalid}, 32'b11);
        #2 reset = 1;
        #1;
        chk("t6_reset_outputs", {21'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, stale},
            32'd0);
        chk("t6_reset_rdata_leds", {rdata[27:0], leds}, 32'd0);
        @(negedge clk); reset = 0;
        repeat (2) @(posedge clk);
        chk("t6_leds_after", {28'd0, leds}, 32'd0);
        rd(32'h4000_0004, d, resp);
        chk("t6_wcount_after", d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
